// File: rtl/instruction_assembler.sv
// Assembles host-link bytes into 32-bit words (LSB first) and queues them,
// releasing one word per cycle while blanking so updates never tear a line.
module instruction_assembler #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_byte,
  input  logic                    i_byte_valid,
  input  logic                    i_blanking,
  output logic [31:0]             o_instruction,
  output logic                    o_instruction_ready,
  output logic [$clog2(DEPTH):0]  o_fifo_level,
  output logic                    o_frame_error,
  output logic                    o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [23:0]     lanes_q;
  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     instr_q;
  logic            rdy_q;
  logic            ferr_q;
  logic            ovf_q;

  logic            timeout;
  logic            push_req;
  logic            push_ok;
  logic            drop;
  logic            pop;
  logic            full;
  logic [31:0]     word;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (i_byte_valid) begin
          cnt_d   = 2'd1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (i_byte_valid) begin
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_q == TMAX) begin
          timeout = 1'b1;
          cnt_d   = 2'd0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
  end

  // A push into an empty FIFO is never popped on the same edge: pop
  // looks only at the registered level.
  always_comb begin
    push_req = i_byte_valid && (state_q == COLLECT) && (cnt_q == 2'd3);
    word     = {i_byte, lanes_q};
    full     = (level_q == FULL);
    pop      = (level_q != '0) && i_blanking;
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= 2'd0;
      tmo_q   <= '0;
      lanes_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      instr_q <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      level_q <= level_d;
      ferr_q  <= timeout;
      rdy_q   <= pop;
      instr_q <= pop ? mem_q[rptr_q] : 32'h0;
      if (drop) ovf_q <= 1'b1;
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (i_byte_valid) begin
        case (cnt_q)
          2'd0:    lanes_q[7:0]   <= i_byte;
          2'd1:    lanes_q[15:8]  <= i_byte;
          2'd2:    lanes_q[23:16] <= i_byte;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && push_ok) mem_q[wptr_q] <= word;
  end

  assign o_instruction       = instr_q;
  assign o_instruction_ready = rdy_q;
  assign o_fifo_level        = level_q;
  assign o_frame_error       = ferr_q;
  assign o_overflow          = ovf_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: assembly, release gating,
// timeout resync, overflow, full-with-pop and reset behaviour.
module tb_instruction_assembler;

  logic        clk;
  logic        rst;
  logic [7:0]  bt;
  logic        bv;
  logic        blank;
  logic [31:0] instr;
  logic        rdy;
  logic [2:0]  level;
  logic        ferr;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int nz_cnt   = 0;
  logic [31:0] cap[$];
  logic [31:0] w[5];

  instruction_assembler #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_byte(bt),
    .i_byte_valid(bv),
    .i_blanking(blank),
    .o_instruction(instr),
    .o_instruction_ready(rdy),
    .o_fifo_level(level),
    .o_frame_error(ferr),
    .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy) cap.push_back(instr);
    if (!rdy && instr != 32'h0) nz_cnt++;
    if (ferr) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bt = b;
    bv = 1'b1;
    tick(1);
    bv = 1'b0;
    bt = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send_byte(v[i*8 +: 8]);
  endtask

  task automatic test_reset;
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", rdy); end
    n_checks++;
    if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", instr); end
    n_checks++;
    if (ferr !== 1'b0) begin n_fail++; $display("FAIL rst_ferr got %b want 0", ferr); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", ovf); end
  endtask

  task automatic test_single;
    blank = 1'b0;
    cap.delete();
    send_byte(8'h01); send_byte(8'hAB); send_byte(8'h0C); send_byte(8'h00);
    n_checks++;
    if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    tick(2);
    n_checks++;
    if (cap.size() != 0) begin n_fail++; $display("FAIL single_nostrobe got %0d want 0", cap.size()); end
    blank = 1'b1;
    tick(1);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h000CAB01) begin
      n_fail++; $display("FAIL single_word got %b/%h want 1/000cab01", rdy, instr);
    end
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL single_level0 got %0d want 0", level); end
    tick(1);
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL single_onepulse got %b want 0", rdy); end
    tick(2);
    n_checks++;
    if (cap.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", cap.size()); end
    blank = 1'b0;
  endtask

  task automatic test_back_to_back;
    blank = 1'b1;
    cap.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    n_checks++;
    if (level !== 3'd1 || rdy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_push got %0d/%b want 1/0", level, rdy);
    end
    send_byte(8'h06);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h00000002) begin
      n_fail++; $display("FAIL b2b_w0 got %b/%h want 1/00000002", rdy, instr);
    end
    send_byte(8'h00);
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b want 0", rdy); end
    send_byte(8'h00); send_byte(8'h00);
    tick(1);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h00000006) begin
      n_fail++; $display("FAIL b2b_w1 got %b/%h want 1/00000006", rdy, instr);
    end
    tick(1);
    n_checks++;
    if (cap.size() != 2 || level !== 3'd0) begin
      n_fail++; $display("FAIL b2b_total got %0d/%0d want 2/0", cap.size(), level);
    end
    blank = 1'b0;
  endtask

  task automatic test_timeout;
    blank = 1'b0;
    ferr_cnt = 0;
    send_byte(8'h01); send_byte(8'h55);
    tick(15);
    n_checks++;
    if (ferr_cnt != 0 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early got %0d/%b want 0/0", ferr_cnt, ferr);
    end
    tick(1);
    n_checks++;
    if (ferr !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got %b want 1", ferr); end
    tick(1);
    n_checks++;
    if (ferr !== 1'b0 || ferr_cnt != 1 || level !== 3'd0) begin
      n_fail++; $display("FAIL tmo_after got %b/%0d/%0d want 0/1/0", ferr, ferr_cnt, level);
    end
    blank = 1'b1;
    send_word(32'h00000004);
    tick(1);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h00000004) begin
      n_fail++; $display("FAIL tmo_resync got %b/%h want 1/00000004", rdy, instr);
    end
    // byte on the last allowed cycle must beat the timeout
    send_byte(8'h07);
    tick(15);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tick(1);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h00000007 || ferr_cnt != 1) begin
      n_fail++; $display("FAIL tmo_edge got %b/%h/%0d want 1/00000007/1", rdy, instr, ferr_cnt);
    end
    tick(1);
    blank = 1'b0;
  endtask

  task automatic test_overflow;
    blank = 1'b0;
    cap.delete();
    for (int i = 0; i < 4; i++) send_word(w[i]);
    n_checks++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill got %0d/%b want 4/0", level, ovf);
    end
    send_word(w[4]);
    n_checks++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop got %0d/%b want 4/1", level, ovf);
    end
    blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (rdy !== 1'b1 || instr !== w[i]) begin
        n_fail++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, rdy, instr, w[i]);
      end
    end
    tick(3);
    n_checks++;
    if (cap.size() != 4 || level !== 3'd0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_end got %0d/%0d/%b want 4/0/1", cap.size(), level, ovf);
    end
    blank = 1'b0;
  endtask

  task automatic test_full_pop;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL fp_rst_ovf got %b want 0", ovf); end
    blank = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    send_byte(w[4][7:0]); send_byte(w[4][15:8]); send_byte(w[4][23:16]);
    blank = 1'b1;
    send_byte(w[4][31:24]);
    n_checks++;
    if (level !== 3'd4 || ovf !== 1'b0 || rdy !== 1'b1 || instr !== w[0]) begin
      n_fail++;
      $display("FAIL fp_edge got %0d/%b/%b/%h want 4/0/1/%h", level, ovf, rdy, instr, w[0]);
    end
    for (int i = 1; i < 5; i++) begin
      tick(1);
      n_checks++;
      if (rdy !== 1'b1 || instr !== w[i]) begin
        n_fail++; $display("FAIL fp_drain%0d got %b/%h want 1/%h", i, rdy, instr, w[i]);
      end
    end
    tick(1);
    n_checks++;
    if (rdy !== 1'b0 || level !== 3'd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL fp_end got %b/%0d/%b want 0/0/0", rdy, level, ovf);
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_mid;
    blank = 1'b0;
    send_word(w[0]); send_word(w[1]);
    send_byte(8'hEE); send_byte(8'hDD);
    n_checks++;
    if (level !== 3'd2) begin n_fail++; $display("FAIL rm_level got %0d want 2", level); end
    rst = 1'b1;
    blank = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if (level !== 3'd0 || rdy !== 1'b0) begin
      n_fail++; $display("FAIL rm_cleared got %0d/%b want 0/0", level, rdy);
    end
    cap.delete();
    tick(3);
    n_checks++;
    if (cap.size() != 0) begin n_fail++; $display("FAIL rm_nostrobe got %0d want 0", cap.size()); end
    send_word(32'h00000005);
    tick(1);
    n_checks++;
    if (rdy !== 1'b1 || instr !== 32'h00000005) begin
      n_fail++; $display("FAIL rm_word got %b/%h want 1/00000005", rdy, instr);
    end
    tick(1);
    blank = 1'b0;
  endtask

  initial begin
    w[0] = 32'h11223344;
    w[1] = 32'hA5A55A5A;
    w[2] = 32'h0000FF01;
    w[3] = 32'hDEADBEEF;
    w[4] = 32'h76543210;
    rst = 1'b1;
    bt = 8'h00;
    bv = 1'b0;
    blank = 1'b0;
    tick(2);
    test_reset();
    rst = 1'b0;
    tick(1);
    test_single();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    n_checks++;
    if (nz_cnt != 0) begin n_fail++; $display("FAIL idle_instr_zero got %0d want 0", nz_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
